// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the RV32I datapath.
// The mem_ready handshake signal exists only when MEM_READY_EN is defined.
// INSTRET_W must match the INSTRET_W of the attached controller.
interface multicycle_controller_if #(
  parameter int unsigned INSTRET_W = 32
) ();
  // Datapath to controller
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 zero;
`ifdef MEM_READY_EN
  logic                 mem_ready;
`endif
  // Controller to datapath
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic [1:0]           result_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [2:0]           imm_src;
  logic                 illegal_op;
  logic [INSTRET_W-1:0] instret;

`ifdef MEM_READY_EN
  modport master (
    input  op, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_op, instret
  );
  modport slave (
    output op, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_op, instret
  );
`else
  modport master (
    input  op, funct3, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_op, instret
  );
  modport slave (
    output op, funct3, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_op, instret
  );
`endif
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle RV32I datapath, with an instructions-retired
// counter and unsupported-opcode flag.
// Optional feature: define MEM_READY_EN to add the mem_ready handshake; FETCH,
// MEMREAD and MEMWRITE then wait for mem_ready=1.
module multicycle_controller #(
  parameter int unsigned INSTRET_W = 32
) (
  input logic                    clk,
  input logic                    reset_n,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StJal,
    StBeq
  } state_e;

  state_e               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic       mem_rdy;
  logic       retire;
  logic       pc_update;
  logic       branch;
  logic       taken;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic       illegal;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_src;

`ifdef MEM_READY_EN
  assign mem_rdy = bus.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // State and retired-instruction counter; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next state and state-decoded control word.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    taken      = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      StFetch: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // IR and PC load only in the cycle memory delivers the instruction
        ir_write   = mem_rdy;
        pc_update  = mem_rdy;
        if (mem_rdy) state_d = StDecode;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (mem_rdy) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        // Held high until the write is accepted
        mem_write = 1'b1;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        case (bus.funct3)
          F3Beq:   taken = bus.zero;
          F3Bne:   taken = ~bus.zero;
          default: illegal = 1'b1;
        endcase
        retire  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    imm_src = 3'b000;
    case (bus.op)
      OpStore:  imm_src = 3'b001;
      OpBranch: imm_src = 3'b010;
      OpJal:    imm_src = 3'b011;
      default:  imm_src = 3'b000;
    endcase
  end

  assign instret_d = instret_q + INSTRET_W'(retire);

  // Write enables are suppressed while reset is held; other outputs follow the state.
  assign bus.pc_write   = reset_n & (pc_update | (branch & taken));
  assign bus.ir_write   = reset_n & ir_write;
  assign bus.reg_write  = reset_n & reg_write;
  assign bus.mem_write  = reset_n & mem_write;
  assign bus.adr_src    = adr_src;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.imm_src    = imm_src;
  assign bus.illegal_op = illegal;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, cycle-level
// corner sequences, and randomized instruction streams against an instruction-level model.
module tb_multicycle_controller;

  localparam int unsigned IW = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   model_instret = 0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.INSTRET_W(IW)) cif ();

  multicycle_controller #(.INSTRET_W(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (cif)
  );

  // Per-instruction observable summary; imm = 8'hFF means not checked.
  typedef struct packed {
    logic [7:0] lat;
    logic [7:0] regw;
    logic [7:0] memw;
    logic [7:0] pcw;
    logic [7:0] ill;
    logic [7:0] ret;
    logic [7:0] wbsrc;
    logic [7:0] imm;
  } exp_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    exp_t       e;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic z,
                              input int lat, input int regw, input int memw, input int pcw,
                              input int ill, input int ret, input int wbsrc, input int imm);
    vec_t v;
    v.op = op; v.f3 = f3; v.z = z;
    v.e.lat = 8'(lat); v.e.regw = 8'(regw); v.e.memw = 8'(memw); v.e.pcw = 8'(pcw);
    v.e.ill = 8'(ill); v.e.ret = 8'(ret); v.e.wbsrc = 8'(wbsrc); v.e.imm = 8'(imm);
    return v;
  endfunction

  // Instruction-level reference: what one instruction must look like from outside.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic z);
    exp_t e;
    int   taken;
    e = '0;
    e.wbsrc = 8'd3;
    e.imm   = 8'hFF;
    e.pcw   = 8'd1;
    case (op)
      7'b0000011: begin e.lat = 8'd5; e.regw = 8'd1; e.ret = 8'd1; e.wbsrc = 8'd1; e.imm = 8'd0; end
      7'b0100011: begin e.lat = 8'd4; e.memw = 8'd1; e.ret = 8'd1; e.imm = 8'd1; end
      7'b0110011: begin e.lat = 8'd4; e.regw = 8'd1; e.ret = 8'd1; e.wbsrc = 8'd0; end
      7'b0010011: begin e.lat = 8'd4; e.regw = 8'd1; e.ret = 8'd1; e.wbsrc = 8'd0; e.imm = 8'd0; end
      7'b1101111: begin
        e.lat = 8'd4; e.regw = 8'd1; e.ret = 8'd1; e.wbsrc = 8'd0; e.pcw = 8'd2; e.imm = 8'd3;
      end
      7'b1100011: begin
        taken = (f3 == 3'd0) ? int'(z) : (f3 == 3'd1) ? int'(!z) : 0;
        e.lat = 8'd3; e.ret = 8'd1; e.imm = 8'd2;
        e.pcw = 8'(1 + taken);
        e.ill = (f3 > 3'd1) ? 8'd1 : 8'd0;
      end
      default: begin e.lat = 8'd2; e.ill = 8'd1; end
    endcase
    return e;
  endfunction

  // Runs one instruction starting mid-cycle in FETCH; ends mid-cycle in the next FETCH.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           output exp_t m);
    int cyc;
    bit done;
    m = '0;
    m.wbsrc = 8'd3;
    cif.op = op; cif.funct3 = f3; cif.zero = z;
    #1;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      if (cif.reg_write) begin
        m.regw  = m.regw + 8'd1;
        m.wbsrc = 8'(cif.result_src);
      end
      m.memw = m.memw + 8'(cif.mem_write);
      m.pcw  = m.pcw + 8'(cif.pc_write);
      m.ill  = m.ill + 8'(cif.illegal_op);
      if (cyc == 1) m.imm = 8'(cif.imm_src);
      @(posedge clk); #2;
      cyc++;
      if (cif.ir_write) begin
        done = 1'b1;
      end else if (cyc > 20) begin
        total++;
        bad++;
        $display("FAIL timeout: op %b still running after %0d cycles, required return to fetch",
                 op, cyc);
        done = 1'b1;
      end
    end
    m.lat = 8'(cyc);
  endtask

  task automatic compare(input string tag, input exp_t m, input exp_t e);
    check({tag, ".latency"}, 32'(m.lat), 32'(e.lat));
    check({tag, ".reg_write"}, 32'(m.regw), 32'(e.regw));
    check({tag, ".mem_write"}, 32'(m.memw), 32'(e.memw));
    check({tag, ".pc_write"}, 32'(m.pcw), 32'(e.pcw));
    check({tag, ".illegal"}, 32'(m.ill), 32'(e.ill));
    check({tag, ".wb_src"}, 32'(m.wbsrc), 32'(e.wbsrc));
    if (e.imm != 8'hFF) check({tag, ".imm_src"}, 32'(m.imm), 32'(e.imm));
    model_instret = (model_instret + int'(e.ret)) % (1 << IW);
    check({tag, ".instret"}, 32'(cif.instret), 32'(model_instret));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #2;
    check("rst.we_c1", 32'({cif.pc_write, cif.ir_write, cif.reg_write, cif.mem_write}), 32'd0);
    @(posedge clk); #2;
    check("rst.we_c2", 32'({cif.pc_write, cif.ir_write, cif.reg_write, cif.mem_write}), 32'd0);
    reset_n = 1'b1;
    #1;
    model_instret = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    exp_t e;
    logic [6:0] ops [6];
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;

    reset_n = 1'b0;
    cif.op = 7'd0; cif.funct3 = 3'd0; cif.zero = 1'b0;
`ifdef MEM_READY_EN
    cif.mem_ready = 1'b1;
`endif

    vecs[0]  = mk(7'b0000011, 3'd2, 1'b0, 5, 1, 0, 1, 0, 1, 1, 0);    // lw
    vecs[1]  = mk(7'b0100011, 3'd2, 1'b0, 4, 0, 1, 1, 0, 1, 3, 1);    // sw
    vecs[2]  = mk(7'b0110011, 3'd0, 1'b0, 4, 1, 0, 1, 0, 1, 0, 255);  // add
    vecs[3]  = mk(7'b0010011, 3'd0, 1'b1, 4, 1, 0, 1, 0, 1, 0, 0);    // addi
    vecs[4]  = mk(7'b1101111, 3'd0, 1'b0, 4, 1, 0, 2, 0, 1, 0, 3);    // jal
    vecs[5]  = mk(7'b1100011, 3'd0, 1'b1, 3, 0, 0, 2, 0, 1, 3, 2);    // beq taken
    vecs[6]  = mk(7'b1100011, 3'd0, 1'b0, 3, 0, 0, 1, 0, 1, 3, 2);    // beq not taken
    vecs[7]  = mk(7'b1100011, 3'd1, 1'b1, 3, 0, 0, 1, 0, 1, 3, 2);    // bne not taken
    vecs[8]  = mk(7'b1100011, 3'd1, 1'b0, 3, 0, 0, 2, 0, 1, 3, 2);    // bne taken
    vecs[9]  = mk(7'b1100011, 3'd4, 1'b1, 3, 0, 0, 1, 1, 1, 3, 2);    // unsupported branch
    vecs[10] = mk(7'b0110111, 3'd0, 1'b0, 2, 0, 0, 1, 1, 0, 3, 255);  // lui: illegal

    // Reset and FETCH encoding after release
    do_reset();
    check("rst.ir_write", 32'(cif.ir_write), 32'd1);
    check("rst.pc_write", 32'(cif.pc_write), 32'd1);
    check("rst.alu_src_a", 32'(cif.alu_src_a), 32'd0);
    check("rst.alu_src_b", 32'(cif.alu_src_b), 32'd2);
    check("rst.alu_op", 32'(cif.alu_op), 32'd0);
    check("rst.result_src", 32'(cif.result_src), 32'd2);
    check("rst.misc", 32'({cif.adr_src, cif.reg_write, cif.mem_write, cif.illegal_op}), 32'd0);
    check("rst.instret", 32'(cif.instret), 32'd0);

    // add, cycle by cycle
    cif.op = 7'b0110011; cif.funct3 = 3'd0; cif.zero = 1'b0;
    @(posedge clk); #2;
    check("add.dec_ab", 32'({cif.alu_src_a, cif.alu_src_b, cif.alu_op}), 32'b01_01_00);
    check("add.dec_ir", 32'(cif.ir_write), 32'd0);
    @(posedge clk); #2;
    check("add.exec_ab", 32'({cif.alu_src_a, cif.alu_src_b, cif.alu_op}), 32'b10_00_10);
    @(posedge clk); #2;
    check("add.wb", 32'({cif.reg_write, cif.result_src}), 32'b1_00);
    check("add.wb_instret", 32'(cif.instret), 32'd0);
    @(posedge clk); #2;
    check("add.fetch", 32'(cif.ir_write), 32'd1);
    check("add.instret", 32'(cif.instret), 32'd1);
    model_instret = 1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].z, m);
      compare($sformatf("vec%0d", i), m, vecs[i].e);
    end

    // Reset mid-instruction: write enable drops at once, instruction does not retire
    do_reset();
    cif.op = 7'b0110011;
    @(posedge clk); #2;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("abort.reg_write", 32'(cif.reg_write), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    #1;
    check("abort.fetch", 32'(cif.ir_write), 32'd1);
    check("abort.instret", 32'(cif.instret), 32'd0);
    model_instret = 0;

    // Counter wrap: all-ones then one more add -> 0
    for (int i = 0; i < (1 << IW) - 1; i++) run_instr(7'b0110011, 3'd0, 1'b0, m);
    check("wrap.all_ones", 32'(cif.instret), 32'((1 << IW) - 1));
    run_instr(7'b0110011, 3'd0, 1'b0, m);
    check("wrap.zero", 32'(cif.instret), 32'd0);
    model_instret = 0;

    // Randomized stream against the instruction-level model
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 6) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 5)];
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      z  = 1'($urandom);
      e  = model(op, f3, z);
      run_instr(op, f3, z, m);
      compare($sformatf("rnd%0d", i), m, e);
    end

`ifdef MEM_READY_EN
    // Fetch waits on memory, then store waits and is aborted by reset
    do_reset();
    cif.mem_ready = 1'b0;
    cif.op = 7'b0100011;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mr.fetch_wait%0d", i), 32'({cif.ir_write, cif.pc_write}), 32'd0);
      @(posedge clk); #2;
    end
    cif.mem_ready = 1'b1;
    #1;
    check("mr.fetch_load", 32'({cif.ir_write, cif.pc_write}), 32'b11);
    @(posedge clk); #2;
    check("mr.decode", 32'({cif.ir_write, cif.alu_src_a}), 32'b0_01);
    @(posedge clk); #2;
    cif.mem_ready = 1'b0;
    @(posedge clk); #2;
    check("mr.memwrite0", 32'(cif.mem_write), 32'd1);
    @(posedge clk); #2;
    check("mr.memwrite_held", 32'({cif.mem_write, cif.adr_src}), 32'b11);
    reset_n = 1'b0;
    #1;
    check("mr.rst_mem_write", 32'(cif.mem_write), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    cif.mem_ready = 1'b1;
    #1;
    check("mr.rst_fetch", 32'(cif.ir_write), 32'd1);
    check("mr.rst_instret", 32'(cif.instret), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
